// File: rtl/icache_axi_refill_pkg.sv
// icache_axi_refill_pkg: AXI constants and refill FSM encoding shared by the refill engine
package icache_axi_refill_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         OFFSET_W       = 5;
  typedef enum logic [1:0] {
    REFILL_IDLE,
    REFILL_AR,
    REFILL_R,
    REFILL_DONE
  } refill_state_e;
endpackage

// File: rtl/icache_axi_refill.sv
// icache_axi_refill: turns one ICache miss into an aligned 8-beat AXI INCR burst and returns the assembled line
module icache_axi_refill
  import icache_axi_refill_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BEAT_W     = 32,
  parameter int LINE_BEATS = 8,
  parameter int ID_W       = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_ren_i,
  input  logic [ADDR_W-1:0]            mem_araddr_i,
  output logic                         mem_rvalid_o,
  output logic [BEAT_W*LINE_BEATS-1:0] mem_rdata_o,
  output logic                         err_o,
  output logic [ID_W-1:0]              arid,
  output logic [ADDR_W-1:0]            araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [ID_W-1:0]              rid,
  input  logic [1:0]                   rresp,
  input  logic [BEAT_W-1:0]            rdata,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready
);
  localparam int CNT_W = $clog2(LINE_BEATS);
  refill_state_e state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [LINE_BEATS-1:0][BEAT_W-1:0] line;
  logic beat;
  logic unused_in;
  assign beat         = rvalid && rready;
  assign arvalid      = state == REFILL_AR;
  assign rready       = state == REFILL_R;
  assign mem_rvalid_o = state == REFILL_DONE;
  assign mem_rdata_o  = line;
  assign arid         = ID_W'(AXI_ID);
  assign arlen        = 8'(LINE_BEATS - 1);
  assign arsize       = AXI_SIZE_4B;
  assign arburst      = AXI_BURST_INCR;
  assign unused_in    = ^{rid, mem_araddr_i[OFFSET_W-1:0]};
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= REFILL_IDLE;
      araddr <= '0;
      cnt    <= '0;
      line   <= '0;
      err_o  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == REFILL_IDLE && mem_ren_i) araddr <= {mem_araddr_i[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
      cnt <= (state == REFILL_IDLE) ? '0 : cnt + CNT_W'(beat);
      if (beat) line[cnt] <= rdata;
      // bad response, rlast on a beat other than the last, or a full line without rlast
      if (beat && (rresp != AXI_RESP_OKAY || rlast != (cnt == CNT_W'(LINE_BEATS - 1)))) err_o <= 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    unique case (state)
      REFILL_IDLE: state_n = mem_ren_i ? REFILL_AR : REFILL_IDLE;
      REFILL_AR:   state_n = arready ? REFILL_R : REFILL_AR;
      REFILL_R:    state_n = (beat && rlast) ? REFILL_DONE : REFILL_R;
      REFILL_DONE: state_n = REFILL_IDLE;
      default:     state_n = REFILL_IDLE;
    endcase
  end
endmodule

// File: tb/tb_icache_axi_refill.sv
// tb_icache_axi_refill: directed misses against a scripted AXI slave; lines and ARs checked by scoreboard monitors
module tb_icache_axi_refill;
  logic clk = 0, rst = 0;
  logic mem_ren_i = 0;
  logic [31:0] mem_araddr_i = 0;
  logic mem_rvalid_o, err_o, arvalid, rready;
  logic [255:0] mem_rdata_o;
  logic [3:0] arid, rid = 0;
  logic [31:0] araddr, rdata = 0;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst, rresp = 0;
  logic arready = 0, rlast = 0, rvalid = 0;
  int checks = 0, errors = 0;
  logic [255:0] exp_q[$];
  logic err_q[$];
  logic [31:0] ar_q[$];
  logic [255:0] model = 0;
  logic err_m = 0;

  icache_axi_refill dut (
    .clk(clk), .rst(rst), .mem_ren_i(mem_ren_i), .mem_araddr_i(mem_araddr_i),
    .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o), .err_o(err_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rresp(rresp), .rdata(rdata),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a, input int k);
    return a ^ (32'h1111_1111 * 32'(k + 1));
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid && rready) assert (rid == 4'd0);
    if (mem_rvalid_o) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        chk("line", mem_rdata_o, exp_q.pop_front());
        chk("err_at_pulse", 256'(err_o), 256'(err_q.pop_front()));
      end
    end
    if (arvalid && arready) begin
      if (ar_q.size() == 0) chk("unexpected_ar", 1, 0);
      else begin
        chk("araddr", 256'(araddr), 256'(ar_q.pop_front()));
        chk("ar_const", 256'({arid, arlen, arsize, arburst}), 256'({4'd0, 8'd7, 3'b010, 2'b01}));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ar(output logic [31:0] a0);
    int n = 0;
    while (!arvalid && n < 20) begin step(); n++; end
    chk("ar_timeout", 256'(arvalid), 1);
    a0 = araddr;
  endtask

  task automatic miss(input logic [31:0] addr, input logic [31:0] exp_ar, input int ar_wait,
                      input logic [15:0] gaps, input int bad_beat, input int last_beat, input bit chg);
    logic [31:0] a0;
    for (int b = 0; b <= last_beat; b++) model[32*(b%8) +: 32] = dat(exp_ar, b);
    err_m = err_m | (bad_beat >= 0 && bad_beat <= last_beat) | (last_beat != 7);
    exp_q.push_back(model);
    err_q.push_back(err_m);
    ar_q.push_back(exp_ar);
    mem_ren_i = 1;
    mem_araddr_i = addr;
    wait_ar(a0);
    for (int i = 0; i < ar_wait; i++) begin
      step();
      chk("ar_hold", 256'({arvalid, araddr}), 256'({1'b1, exp_ar}));
    end
    arready = 1;
    step();
    arready = 0;
    for (int b = 0; b <= last_beat; b++) begin
      if (gaps[b]) begin rvalid = 0; step(); end
      if (chg && b == 2) mem_araddr_i = 32'hDEAD_BEE0;
      rvalid = 1;
      rdata = dat(a0, b);
      rresp = (b == bad_beat) ? 2'b10 : 2'b00;
      rlast = (b == last_beat);
      if (b == 0 || gaps[b]) chk("rready", 256'(rready), 1);
      step();
    end
    rvalid = 0;
    rlast = 0;
    rresp = 0;
    mem_ren_i = 0;
    step();
  endtask

  initial begin
    logic [31:0] a0;
    repeat (3) step();
    chk("rst_outs", 256'({arvalid, rready, mem_rvalid_o, err_o}), 0);
    chk("rst_line", mem_rdata_o, 0);
    rst = 1;
    step();
    miss(32'h1FC0_0024, 32'h1FC0_0020, 0, 16'h0, -1, 7, 0);
    chk("err_clean", 256'(err_o), 0);
    miss(32'h1FC0_0024, 32'h1FC0_0020, 5, 16'h0048, -1, 7, 0);
    miss(32'h0000_0100, 32'h0000_0100, 0, 16'h0, -1, 7, 0);
    miss(32'h0000_0200, 32'h0000_0200, 1, 16'h0, -1, 7, 0);
    repeat (4) step();
    chk("no_third_ar", 256'(arvalid), 0);
    miss(32'h0000_0300, 32'h0000_0300, 0, 16'h0, -1, 7, 1);
    chk("err_clean2", 256'(err_o), 0);
    miss(32'h0000_1008, 32'h0000_1000, 0, 16'h0, 3, 7, 0);
    repeat (3) step();
    chk("err_sticky", 256'(err_o), 1);
    miss(32'h0000_2000, 32'h0000_2000, 0, 16'h0, -1, 5, 0);
    miss(32'h0000_3000, 32'h0000_3000, 0, 16'h0, -1, 8, 0);
    rst = 0;
    step();
    rst = 1;
    model = 0;
    err_m = 0;
    chk("err_cleared", 256'(err_o), 0);
    ar_q.push_back(32'h0000_0400);
    mem_ren_i = 1;
    mem_araddr_i = 32'h0000_0410;
    wait_ar(a0);
    arready = 1;
    step();
    arready = 0;
    for (int b = 0; b < 4; b++) begin
      rvalid = 1;
      rdata = dat(a0, b);
      step();
    end
    rvalid = 1;
    rdata = dat(a0, 4);
    rst = 0;
    mem_ren_i = 0;
    step();
    rvalid = 0;
    chk("midrst_outs", 256'({arvalid, rready, mem_rvalid_o, err_o}), 0);
    chk("midrst_line", mem_rdata_o, 0);
    rst = 1;
    step();
    miss(32'h0000_0500, 32'h0000_0500, 2, 16'h0010, -1, 7, 0);
    repeat (5) step();
    chk("lines_left", 256'(exp_q.size()), 0);
    chk("ars_left", 256'(ar_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end
endmodule
